// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1
  } hz_state_e;

  // A load in EX whose destination is read by the instruction in ID.
  // x0 is hardwired to zero, so it never creates a dependency.
  function automatic logic is_load_use(
    input logic       ex_mem_read,
    input logic [4:0] ex_rd,
    input logic [4:0] id_rs1,
    input logic       id_use_rs1,
    input logic [4:0] id_rs2,
    input logic       id_use_rs2
  );
    return ex_mem_read && (ex_rd != 5'd0) &&
           ((id_use_rs1 && (id_rs1 == ex_rd)) ||
            (id_use_rs2 && (id_rs2 == ex_rd)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter: counts inc cycles and holds at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: advance on inc unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory stalls, load-use interlock, EX
// redirects and multi-cycle mul/div waits, plus stall/flush counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             ex_md_start,
  input  logic             md_done,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_clear,
  output logic             id_ex_clear,
  output logic             ex_mem_clear,
  output logic             mem_wb_clear,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state
);

  hz_state_e state_q, state_d;
  logic      md_done_q, md_done_d;
  logic      mem_stall;
  logic      load_use;
  logic      md_fin;
  logic      flush_inc;

  assign mem_stall = dmem_req && !dmem_ack;
  assign load_use  = is_load_use(ex_mem_read, ex_rd, id_rs1, id_use_rs1,
                                 id_rs2, id_use_rs2);
  // A completion seen during a memory stall is remembered until it can act.
  assign md_fin    = md_done || md_done_q;

  // Next state and pipeline controls; memory stall outranks everything,
  // and a redirect outranks a load-use interlock.
  always_comb begin
    state_d      = state_q;
    md_done_d    = md_done_q;
    flush_inc    = 1'b0;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_clear  = 1'b0;
    id_ex_clear  = 1'b0;
    ex_mem_clear = 1'b0;
    mem_wb_clear = 1'b0;
    if (!rst_n) begin
      // Hold the whole pipeline frozen and empty while in reset.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_clear  = 1'b1;
      id_ex_clear  = 1'b1;
      ex_mem_clear = 1'b1;
      mem_wb_clear = 1'b1;
      state_d      = RUN;
      md_done_d    = 1'b0;
    end else if (mem_stall) begin
      // Freeze everything up to MEM; WB receives a bubble. A redirect
      // stays pending because EX is held.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_clear = 1'b1;
      if ((state_q == MD_WAIT) && md_done) begin
        md_done_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (ex_redirect) begin
            if_id_clear = 1'b1;
            id_ex_clear = 1'b1;
            flush_inc   = 1'b1;
          end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_clear = 1'b1;
          end
          if (ex_md_start && !md_done) begin
            state_d = MD_WAIT;
          end
        end
        MD_WAIT: begin
          if (md_fin) begin
            state_d   = RUN;
            md_done_d = 1'b0;
          end else begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_clear = 1'b1;
          end
        end
        default: begin
          state_d   = RUN;
          md_done_d = 1'b0;
        end
      endcase
    end
  end

  // FSM state and sticky mul/div completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      md_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      md_done_q <= md_done_d;
    end
  end

  assign state = state_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!pc_en),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule
